// File: rtl/kinase_seq_pkg.sv
// Shared encodings, state type and valve pattern tables for the kinase
// activity control sequencer.
package kinase_seq_pkg;

    localparam logic [1:0] OP_SET_A = 2'd0;
    localparam logic [1:0] OP_SET_S = 2'd1;
    localparam logic [1:0] OP_PUMP  = 2'd2;
    localparam logic [1:0] OP_WAIT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PUMP = 2'd1,
        ST_WAIT = 2'd2
    } seq_state_t;

    localparam logic [2:0] PUMP_A_PATTERN [6] = '{3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010};
    localparam logic [1:0] PUMP_B_PATTERN [2] = '{2'b10, 2'b01};

    localparam logic [2:0] PUMP_A_REST = 3'b111;
    localparam logic [1:0] PUMP_B_REST = 2'b11;

    // Phase walks modulo the selected pattern length: 6 for pump_a, 2 for pump_b.
    function automatic logic [2:0] step_phase(input logic [2:0] phase,
                                              input logic       rev,
                                              input logic       sel_b);
        logic [2:0] last;
        last = sel_b ? 3'd1 : 3'd5;
        if (rev) begin
            return (phase == 3'd0) ? last : phase - 3'd1;
        end
        return (phase == last) ? 3'd0 : phase + 3'd1;
    endfunction

endpackage

// File: rtl/kinase_activity_seq_prescaler.sv
// Free-running tick prescaler; restarted by clear so the first tick after a
// command acceptance lands exactly TICK_DIV clocks later.
module seq_tick_prescaler #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int             CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_count;

    assign tick = (r_count == LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear || tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/kinase_activity_seq.sv
// Command sequencer driving the kinase_activity_2 valve and peristaltic pump
// lines: SET_A / SET_S valve writes, timed PUMP steps and WAIT delays.
module kinase_activity_seq
    import kinase_seq_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int CTRL_A_W = 13,
    parameter int CTRL_S_W = 4,
    parameter int CNT_W    = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [15:0]         cmd_arg,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [CTRL_A_W-1:0] ctrl_a,
    output logic [CTRL_S_W-1:0] ctrl_s,
    output logic [2:0]          pump_a,
    output logic [1:0]          pump_b
);

    seq_state_t          r_state;
    logic [2:0]          r_phase;
    logic [15:0]         r_remaining;
    logic                r_sel_b;
    logic                r_rev;
    logic                r_done;
    logic                r_aborted;
    logic [CTRL_A_W-1:0] r_ctrl_a;
    logic [CTRL_S_W-1:0] r_ctrl_s;
    logic [2:0]          r_pump_a;
    logic [1:0]          r_pump_b;

    seq_state_t          w_state_nxt;
    logic [2:0]          w_phase_nxt;
    logic [15:0]         w_remaining_nxt;
    logic                w_sel_b_nxt;
    logic                w_rev_nxt;
    logic                w_done_nxt;
    logic                w_aborted_nxt;
    logic [CTRL_A_W-1:0] w_ctrl_a_nxt;
    logic [CTRL_S_W-1:0] w_ctrl_s_nxt;
    logic [2:0]          w_pump_a_nxt;
    logic [1:0]          w_pump_b_nxt;

    logic                w_accept;
    logic                w_tick;
    logic [CNT_W-1:0]    w_pump_n;
    logic [2:0]          w_step_phase;

    assign cmd_ready    = (r_state == ST_IDLE) && !abort;
    assign busy         = (r_state != ST_IDLE);
    assign w_accept     = cmd_valid && cmd_ready;
    assign w_pump_n     = cmd_arg[CNT_W-1:0];
    assign w_step_phase = step_phase(r_phase, r_rev, r_sel_b);

    seq_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clear (w_accept),
        .tick  (w_tick)
    );

    // NOTE: every next-state signal is given its hold value first, so no path
    // through the case statements can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_phase_nxt     = r_phase;
        w_remaining_nxt = r_remaining;
        w_sel_b_nxt     = r_sel_b;
        w_rev_nxt       = r_rev;
        w_done_nxt      = 1'b0;
        w_aborted_nxt   = 1'b0;
        w_ctrl_a_nxt    = r_ctrl_a;
        w_ctrl_s_nxt    = r_ctrl_s;
        w_pump_a_nxt    = r_pump_a;
        w_pump_b_nxt    = r_pump_b;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (cmd_op)
                        OP_SET_A: begin
                            w_ctrl_a_nxt = cmd_arg[CTRL_A_W-1:0];
                            w_done_nxt   = 1'b1;
                        end
                        OP_SET_S: begin
                            w_ctrl_s_nxt = cmd_arg[CTRL_S_W-1:0];
                            w_done_nxt   = 1'b1;
                        end
                        OP_PUMP: begin
                            if (w_pump_n == '0) begin
                                w_done_nxt = 1'b1;
                            end else begin
                                w_state_nxt     = ST_PUMP;
                                w_phase_nxt     = 3'd0;
                                w_remaining_nxt = 16'(w_pump_n);
                                w_sel_b_nxt     = cmd_arg[15];
                                w_rev_nxt       = cmd_arg[14];
                                if (cmd_arg[15]) begin
                                    w_pump_b_nxt = PUMP_B_PATTERN[0];
                                end else begin
                                    w_pump_a_nxt = PUMP_A_PATTERN[0];
                                end
                            end
                        end
                        OP_WAIT: begin
                            if (cmd_arg == 16'd0) begin
                                w_done_nxt = 1'b1;
                            end else begin
                                w_state_nxt     = ST_WAIT;
                                w_remaining_nxt = cmd_arg;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ST_PUMP: begin
                // Abort outranks a coincident final tick, so done and aborted never overlap.
                if (abort) begin
                    w_state_nxt   = ST_IDLE;
                    w_pump_a_nxt  = PUMP_A_REST;
                    w_pump_b_nxt  = PUMP_B_REST;
                    w_aborted_nxt = 1'b1;
                end else if (w_tick) begin
                    if (r_remaining == 16'd1) begin
                        w_state_nxt  = ST_IDLE;
                        w_pump_a_nxt = PUMP_A_REST;
                        w_pump_b_nxt = PUMP_B_REST;
                        w_done_nxt   = 1'b1;
                    end else begin
                        w_phase_nxt     = w_step_phase;
                        w_remaining_nxt = r_remaining - 16'd1;
                        if (r_sel_b) begin
                            w_pump_b_nxt = PUMP_B_PATTERN[w_step_phase[0]];
                        end else begin
                            w_pump_a_nxt = PUMP_A_PATTERN[w_step_phase];
                        end
                    end
                end
            end

            ST_WAIT: begin
                if (abort) begin
                    w_state_nxt   = ST_IDLE;
                    w_aborted_nxt = 1'b1;
                end else if (w_tick) begin
                    if (r_remaining == 16'd1) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                    w_remaining_nxt = r_remaining - 16'd1;
                end
            end

            default: begin
                w_state_nxt  = ST_IDLE;
                w_pump_a_nxt = PUMP_A_REST;
                w_pump_b_nxt = PUMP_B_REST;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_phase     <= 3'd0;
            r_remaining <= 16'd0;
            r_sel_b     <= 1'b0;
            r_rev       <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
            r_ctrl_a    <= '0;
            r_ctrl_s    <= '0;
            r_pump_a    <= PUMP_A_REST;
            r_pump_b    <= PUMP_B_REST;
        end else begin
            r_state     <= w_state_nxt;
            r_phase     <= w_phase_nxt;
            r_remaining <= w_remaining_nxt;
            r_sel_b     <= w_sel_b_nxt;
            r_rev       <= w_rev_nxt;
            r_done      <= w_done_nxt;
            r_aborted   <= w_aborted_nxt;
            r_ctrl_a    <= w_ctrl_a_nxt;
            r_ctrl_s    <= w_ctrl_s_nxt;
            r_pump_a    <= w_pump_a_nxt;
            r_pump_b    <= w_pump_b_nxt;
        end
    end

    assign done    = r_done;
    assign aborted = r_aborted;
    assign ctrl_a  = r_ctrl_a;
    assign ctrl_s  = r_ctrl_s;
    assign pump_a  = r_pump_a;
    assign pump_b  = r_pump_b;

endmodule

// File: tb/tb_kinase_activity_seq.sv
// Scoreboard bench for kinase_activity_seq: stimulus pushes expected pulses and
// pump transitions derived from the command rules; a monitor pops and compares.
module tb_kinase_activity_seq;
    import kinase_seq_pkg::*;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_arg = 16'd0;
    logic        abort = 1'b0;
    logic        cmd_ready, busy, done, aborted;
    logic [12:0] ctrl_a;
    logic [3:0]  ctrl_s;
    logic [2:0]  pump_a;
    logic [1:0]  pump_b;

    kinase_activity_seq #(
        .TICK_DIV (D),
        .CTRL_A_W (13),
        .CTRL_S_W (4),
        .CNT_W    (14)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .ctrl_a    (ctrl_a),
        .ctrl_s    (ctrl_s),
        .pump_a    (pump_a),
        .pump_b    (pump_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        bit          is_abort;
        int          at;
        logic [12:0] ca;
        logic [3:0]  cs;
    } resp_t;

    typedef struct {
        int         at;
        logic [2:0] pa;
        logic [1:0] pb;
    } pump_ev_t;

    resp_t    resp_q[$];
    pump_ev_t pump_q[$];
    int       b_start = 0;
    int       b_end   = 0;
    logic [12:0] m_ca = '0;
    logic [3:0]  m_cs = '0;

    logic [2:0] pa_tab [6] = '{3'b110, 3'b100, 3'b101, 3'b001, 3'b011, 3'b010};
    logic [1:0] pb_tab [2] = '{2'b10, 2'b01};

    task automatic check_reset(input string tag);
        check({tag, "_ctrl_a"},    ctrl_a, 0);
        check({tag, "_ctrl_s"},    ctrl_s, 0);
        check({tag, "_pump_a"},    pump_a, 3'b111);
        check({tag, "_pump_b"},    pump_b, 2'b11);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_done"},      done, 0);
        check({tag, "_aborted"},   aborted, 0);
    endtask

    // abort_k > 0: raise abort (with a coincident command) k cycles after accept.
    task automatic issue(input logic [1:0] op, input logic [15:0] arg, input int abort_k);
        int       c, n, len, ph;
        bit       ok, sel_b, rev;
        resp_t    r;
        pump_ev_t ev;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        ok = 1'b0;
        for (int w = 0; w < 500; w++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        c = cyc;
        n = 0;
        case (op)
            OP_SET_A: m_ca = arg[12:0];
            OP_SET_S: m_cs = arg[3:0];
            OP_PUMP:  n = int'(arg[13:0]);
            default:  n = int'(arg);
        endcase
        if (n == 0) abort_k = 0;
        r.is_abort = (abort_k > 0);
        r.ca = m_ca;
        r.cs = m_cs;
        if (n == 0)          r.at = c + 1;
        else if (abort_k > 0) r.at = c + abort_k + 1;
        else                 r.at = c + n * D + 1;
        if (n > 0) begin
            b_start = c;
            b_end   = r.at;
        end
        resp_q.push_back(r);
        if (op == OP_PUMP && n > 0) begin
            sel_b = arg[15];
            rev   = arg[14];
            len   = sel_b ? 2 : 6;
            for (int j = 0; j < n; j++) begin
                if (abort_k > 0 && 1 + j * D > abort_k) break;
                ph    = rev ? (len - (j % len)) % len : j % len;
                ev.at = c + 1 + j * D;
                ev.pa = sel_b ? 3'b111 : pa_tab[ph];
                ev.pb = sel_b ? pb_tab[ph] : 2'b11;
                pump_q.push_back(ev);
            end
            ev.at = r.at;
            ev.pa = 3'b111;
            ev.pb = 2'b11;
            pump_q.push_back(ev);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (abort_k > 0) begin
            repeat (abort_k - 1) begin
                @(posedge clk); #1;
            end
            abort     = 1'b1;
            cmd_valid = 1'b1;
            cmd_op    = OP_SET_A;
            cmd_arg   = 16'($urandom);
            @(negedge clk);
            check("ready_low_during_abort", cmd_ready, 0);
            @(posedge clk); #1;
            abort     = 1'b0;
            cmd_valid = 1'b0;
            @(negedge clk);
            check("ready_after_abort", cmd_ready, 1);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int w = 0; w < 2000; w++) begin
            @(negedge clk);
            if (!busy && resp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    task automatic abort_in_idle();
        wait_idle();
        @(posedge clk); #1;
        abort     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = OP_SET_A;
        cmd_arg   = 16'h0FFF;
        @(negedge clk);
        check("idle_abort_blocks_ready", cmd_ready, 0);
        @(posedge clk); #1;
        abort     = 1'b0;
        cmd_valid = 1'b0;
    endtask

    initial begin : monitor
        logic [2:0] last_pa;
        logic [1:0] last_pb;
        resp_t      r;
        pump_ev_t   ev;
        bit         exp_busy;
        last_pa = 3'b111;
        last_pb = 2'b11;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_pa = 3'b111;
                last_pb = 2'b11;
            end else begin
                exp_busy = (cyc > b_start) && (cyc < b_end);
                check("busy", busy, exp_busy);
                check("done_aborted_exclusive", done & aborted, 0);
                if (done || aborted) begin
                    if (resp_q.size() == 0) begin
                        check("unexpected_pulse", {done, aborted}, 0);
                    end else begin
                        r = resp_q.pop_front();
                        check("aborted_pulse", aborted, r.is_abort);
                        check("done_pulse", done, !r.is_abort);
                        check("pulse_cycle", cyc, r.at);
                        check("ctrl_a_at_pulse", ctrl_a, r.ca);
                        check("ctrl_s_at_pulse", ctrl_s, r.cs);
                    end
                end
                if (pump_a !== last_pa || pump_b !== last_pb) begin
                    if (pump_q.size() == 0) begin
                        check("unexpected_pump_change", {pump_a, pump_b}, {last_pa, last_pb});
                    end else begin
                        ev = pump_q.pop_front();
                        check("pump_value", {pump_a, pump_b}, {ev.pa, ev.pb});
                        check("pump_cycle", cyc, ev.at);
                    end
                    last_pa = pump_a;
                    last_pb = pump_b;
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin : stimulus
        logic [1:0]  op;
        logic [15:0] arg;
        int          n, k;
        rst = 1'b0;
        #2 rst = 1'b1;
        #1 check_reset("por");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        issue(OP_SET_A, 16'h1A5A, 0);
        issue(OP_PUMP,  16'h0003, 0);
        issue(OP_PUMP,  16'h4002, 0);
        issue(OP_PUMP,  16'h8003, 0);
        issue(OP_WAIT,  16'd5, 0);
        issue(OP_WAIT,  16'd0, 0);
        issue(OP_PUMP,  16'h0000, 0);
        issue(OP_PUMP,  16'hC000, 0);
        issue(OP_PUMP,  16'h000A, 9);
        abort_in_idle();
        issue(OP_SET_S, 16'h0006, 0);
        issue(OP_PUMP,  16'hC005, 0);

        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            arg = 16'($urandom);
            n   = 0;
            if (op == OP_PUMP) begin
                n = $urandom_range(0, 5);
                arg[13:0] = 14'(n);
            end else if (op == OP_WAIT) begin
                n   = $urandom_range(0, 5);
                arg = 16'(n);
            end
            k = 0;
            if (n > 0 && $urandom_range(0, 3) == 0) k = $urandom_range(1, n * D);
            issue(op, arg, k);
        end

        wait_idle();
        issue(OP_WAIT, 16'd7, 0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset("midwait");
        resp_q.delete();
        pump_q.delete();
        b_start = 0;
        b_end   = 0;
        m_ca    = '0;
        m_cs    = '0;
        @(posedge clk); #1 rst = 1'b0;
        issue(OP_SET_S, 16'h000F, 0);

        wait_idle();
        repeat (4) @(negedge clk);
        check("final_ctrl_s", ctrl_s, 4'hF);
        check("resp_queue_drained", resp_q.size(), 0);
        check("pump_queue_drained", pump_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kinase_activity_seq.md
Name: kinase_activity_seq

Overview:
- Synchronous control sequencer that sits directly upstream of the kinase_activity_2 pad wrapper.
- Drives the wrapper's valve lines (ctrl_a, ctrl_s) and peristaltic pump lines (pump_a, pump_b).
- A host issues one command at a time over a valid/ready interface: set valves, run a pump for N steps, or wait N ticks.
- Pump and wait timing is derived from a programmable tick prescaler.

Parameters:
- TICK_DIV, 1000, clocks per tick (>=1); one pump step or wait unit equals one tick.
- CTRL_A_W, 13, ctrl_a width.
- CTRL_S_W, 4, ctrl_s width.
- CNT_W, 14, pump step-count width; wait count is always 16 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  0=SET_A, 1=SET_S, 2=PUMP, 3=WAIT.
- cmd_arg  in  16  operand (see Behaviour).
- abort  in  1  cancel the running PUMP/WAIT.
- busy  out  1  high in PUMP or WAIT state.
- done  out  1  one-cycle pulse when a command completes.
- aborted  out  1  one-cycle pulse when abort terminates PUMP/WAIT.
- ctrl_a  out  CTRL_A_W  valve control; 1 = pressurised/closed.
- ctrl_s  out  CTRL_S_W  valve control.
- pump_a  out  3  three-valve peristaltic pump.
- pump_b  out  2  two-valve pump.

Behaviour:
- Reset values (async, immediate):
  - ctrl_a=0, ctrl_s=0.
  - pump_a=3'b111 and pump_b=2'b11 (rest pattern, all valves closed).
  - cmd_ready=1, busy=0, done=0, aborted=0.
  - State IDLE; prescaler, phase and counters all 0.
- States: IDLE, PUMP, WAIT.
  - cmd_ready = (state==IDLE) && !abort.
  - busy = (state!=IDLE).
- Prescaler:
  - Counts 0..TICK_DIV-1; tick pulses in the cycle the count equals TICK_DIV-1, then the count wraps to 0.
  - Cleared on every command acceptance, so the first step lasts exactly TICK_DIV clocks.
  - TICK_DIV=1 gives a tick every cycle.
- SET_A: ctrl_a <= cmd_arg[CTRL_A_W-1:0] on the accept edge; done pulses the following cycle; stays IDLE.
- SET_S: same as SET_A, applied to ctrl_s using cmd_arg[CTRL_S_W-1:0].
- PUMP operand fields:
  - cmd_arg[15] selects the pump: 0=pump_a, 1=pump_b.
  - cmd_arg[14] is the direction: 0=forward, 1=reverse.
  - cmd_arg[CNT_W-1:0] = step count N.
- PUMP with N=0: no state change; done pulses the cycle after accept; pump outputs stay at rest.
- PUMP with N>0:
  - On the accept edge: state goes to PUMP, phase=0, remaining=N, and the selected pump output takes pattern[0]. The unselected pump stays at rest.
  - On each tick with remaining==1: the output returns to rest, state goes to IDLE, and done pulses next cycle.
  - On each other tick: phase advances (+1 forward, -1 reverse, wrapping modulo the pattern length), remaining decrements, and the output takes pattern[phase].
  - Total PUMP duration is N*TICK_DIV clocks.
- pump_a pattern (mod 6), idx0..5: 110, 100, 101, 001, 011, 010.
  - Reverse from idx0 goes to idx5.
- pump_b pattern (mod 2): 10, 01.
- WAIT (operand cmd_arg = T ticks):
  - T=0: done pulses the cycle after accept.
  - T>0: state WAIT; decrement on each tick; on the tick that reaches 0, go to IDLE and pulse done next cycle.
- done timing: done is a registered pulse exactly one cycle long, and never asserts in the same cycle as aborted.
- Abort:
  - In PUMP/WAIT: on the next edge, go to IDLE, pumps return to rest, ctrl_a/ctrl_s are unchanged, aborted pulses one cycle, done does not pulse.
  - In IDLE: no effect except that it blocks acceptance that cycle.
  - Abort and cmd_valid together: abort wins; the command is not accepted.
- Reset mid-command: all state, pumps and counters return to reset values immediately; no done or aborted pulse.
- Commands arriving while busy are held by the host (cmd_ready=0); no queue.

Decomposition:
- Package kinase_seq_pkg holds:
  - the op encodings OP_SET_A/OP_SET_S/OP_PUMP/OP_WAIT;
  - the state enum;
  - the PUMP_A_PATTERN[6] and PUMP_B_PATTERN[2] constant tables;
  - the rest constants PUMP_A_REST=3'b111 and PUMP_B_REST=2'b11.
- One sub-module, seq_tick_prescaler (parameter TICK_DIV; inputs clk, rst, clear; output tick), is reused for both PUMP and WAIT timing.

Test Plan (TICK_DIV=4):
- Reset, then issue SET_A arg=16'h1A5A -> ctrl_a=13'h1A5A the cycle after accept; done high exactly 1 cycle; pumps remain 111/11.
- PUMP arg=16'h0003 (pump_a, forward, N=3) -> pump_a=110 for 4 clks, then 100 for 4 clks, then 101 for 4 clks, then 111; busy high for 12 clks; a single done pulse.
- PUMP arg=16'h4002 (pump_a, reverse, N=2) -> pump_a 110, then 010, then 111. PUMP arg=16'h8003 (pump_b) -> pump_b 10, 01, 10, then 11.
- WAIT arg=5 -> busy for 20 clks, then done. WAIT arg=0 and PUMP N=0 -> done next cycle, busy never high.
- PUMP N=10, abort asserted at clk 9 with cmd_valid also high -> pumps at rest on the next edge; aborted pulses 1 cycle; no done; the coincident command is not accepted; cmd_ready returns high once abort is low.
- Assert rst mid-WAIT -> all outputs go to reset values asynchronously; after release, a new SET_S arg=4'hF is accepted normally.
